// File: rtl/mbe_seq_mult_ctrl_if.sv
// Handshake and result bundle for the sequential radix-4 Booth multiplier.
// master: requester driving start/a/b; slave: multiplier driving status and result.
// Signals: start, a, b (request); ready, busy, done, product, iter_cnt (status/result).
interface mbe_seq_mult_ctrl_if #(
    parameter int N = 8
);
    localparam int CW = $clog2(N / 2) + 1;

    logic            start;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic            ready;
    logic            busy;
    logic            done;
    logic [2*N-1:0]  product;
    logic [CW-1:0]   iter_cnt;

    modport master (
        output start, a, b,
        input  ready, busy, done, product, iter_cnt
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, product, iter_cnt
    );
endinterface

// File: rtl/mbe_seq_mult_ctrl.sv
// Sequential radix-4 Modified Booth multiplier: one Booth digit per clock through one N+2-bit adder.
// Latency: accept at edge 0, done high in the cycle after edge N/2 (fewer edges with early exit).
// Backpressure: start is sampled only while ready (IDLE); requests during ITER/DONE are dropped.
//
// Ports: clk, rst_n (async active-low); bus.slave carries start/a/b in and
//        ready/busy/done/product/iter_cnt out.
// Build option: define MBE_EARLY_EXIT_EN to leave ITER once all remaining Booth digits are zero.
module mbe_seq_mult_ctrl #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mbe_seq_mult_ctrl_if.slave   bus
);
    localparam int              CW   = $clog2(N / 2) + 1;
    localparam logic [CW-1:0]   HALF = CW'(N / 2);

    generate
        if (((N % 2) != 0) || (N < 4)) begin : g_bad_n
            $error("mbe_seq_mult_ctrl: N must be even and at least 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t          state, state_n;
    logic [N-1:0]    a_q;
    // Multiplier shifted right two bits per digit with a zero appended below bit 0,
    // so bits [2:0] are always the current Booth triplet.
    logic [N:0]      b_sr;
    // hi accumulates at the current digit's weight; lo collects the settled low bits.
    logic [N+1:0]    hi;
    logic [N-1:0]    lo;
    logic [CW-1:0]   cnt;
    logic [2*N-1:0]  prod_q;
    logic [CW-1:0]   icnt_q;

    logic [N+1:0]    a_x1, a_x2, mag, addend, sum, hi_n;
    logic [N-1:0]    lo_n;
    logic            neg, last;
    logic [CW-1:0]   cnt_n;
    logic [2*N-1:0]  prod_n;

    // Booth recoding and the single shared adder; negation is ~x plus carry-in.
    always_comb begin
        a_x1   = {{2{a_q[N-1]}}, a_q};
        a_x2   = {a_q[N-1], a_q, 1'b0};
        mag    = '0;
        neg    = 1'b0;
        case (b_sr[2:0])
            3'b001, 3'b010: mag = a_x1;
            3'b011:         mag = a_x2;
            3'b100: begin   mag = a_x2; neg = 1'b1; end
            3'b101, 3'b110: begin mag = a_x1; neg = 1'b1; end
            default:        mag = '0;
        endcase
        addend = neg ? ~mag : mag;
        sum    = hi + addend + {{(N+1){1'b0}}, neg};
        // The running sum never exceeds N+2 signed bits, so an arithmetic shift is exact.
        hi_n   = {sum[N+1], sum[N+1], sum[N+1:2]};
        lo_n   = {sum[1:0], lo[N-1:2]};
        cnt_n  = cnt + CW'(1);
    end

`ifdef MBE_EARLY_EXIT_EN
    logic [CW-1:0] rem;
    always_comb begin
        rem    = HALF - cnt_n;
        // Bits b[N-1:2i+1] sit in b_sr[N:2]; when uniform, every later digit is 000 or 111.
        last   = (cnt_n == HALF) || (&b_sr[N:2]) || (~|b_sr[N:2]);
        // On an early exit {hi,lo} is still scaled up by 4^rem; realign to the true product.
        prod_n = (2*N)'($signed({hi_n, lo_n}) >>> {rem, 1'b0});
    end
`else
    always_comb begin
        last   = (cnt_n == HALF);
        prod_n = {hi_n[N-1:0], lo_n};
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (bus.start) state_n = ITER;
            ITER:    if (last)      state_n = DONE;
            DONE:                   state_n = IDLE;
            default:                state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_sr   <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            prod_q <= '0;
            icnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q  <= bus.a;
                        b_sr <= {bus.b, 1'b0};
                        hi   <= '0;
                        lo   <= '0;
                        cnt  <= '0;
                    end
                end
                ITER: begin
                    hi   <= hi_n;
                    lo   <= lo_n;
                    b_sr <= {b_sr[N], b_sr[N], b_sr[N:2]};
                    cnt  <= cnt_n;
                    if (last) begin
                        prod_q <= prod_n;
                        icnt_q <= cnt_n;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready    = (state == IDLE);
    assign bus.busy     = (state == ITER);
    assign bus.done     = (state == DONE);
    assign bus.product  = prod_q;
    assign bus.iter_cnt = icnt_q;
endmodule

// File: tb/tb_mbe_seq_mult_ctrl.sv
// Directed bench for mbe_seq_mult_ctrl at N=8: reset state, latency, corner products,
// continuous-start streaming, mid-operation reset, and early-exit digit counts.
module tb_mbe_seq_mult_ctrl;
`ifdef MBE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    mbe_seq_mult_ctrl_if #(.N(8)) bus ();

    mbe_seq_mult_ctrl #(.N(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Iteration count for multiplier bv: N/2, or the first digit after which b's upper bits are uniform.
    function automatic int exp_cnt(input logic [7:0] bv);
        logic [7:0] s;
        if (!EE) return 4;
        for (int i = 0; i < 4; i++) begin
            s = $signed(bv) >>> (2 * i + 1);
            if (s == 8'h00 || s == 8'hFF) return i + 1;
        end
        return 4;
    endfunction

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!bus.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, bus.ready, 1'b1);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] ep, input int ec, input string tag);
        int n;
        wait_ready(tag);
        bus.start = 1'b1;
        bus.a = av;
        bus.b = bv;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = ~av;
        bus.b = ~bv;
        chk({tag, "_busy"}, bus.busy, 1'b1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_lat"}, n, ec);
        chk({tag, "_prod"}, bus.product, ep);
        chk({tag, "_cnt"}, bus.iter_cnt, ec);
        chk({tag, "_rdy_in_done"}, bus.ready, 1'b0);
        @(negedge clk);
        chk({tag, "_pulse"}, bus.done, 1'b0);
        chk({tag, "_hold"}, bus.product, ep);
    endtask

    initial begin
        logic signed [7:0]  sa, sb;
        logic signed [15:0] pe;
        logic [15:0]        eq[$];
        int                 ecq[$];
        int                 acc_n, done_n, last_done, c_pop;
        logic               seen;

        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_product", bus.product, 16'h0000);
        chk("rst_iter_cnt", bus.iter_cnt, 3'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic and corner products
        run_op(8'd3, 8'd5, 16'h000F, EE ? 2 : 4, "a3_b5");
        run_op(8'h80, 8'h80, 16'h4000, 4, "min_min");
        run_op(8'h80, 8'h7F, 16'hC080, 4, "min_max");
        run_op(8'h7F, 8'hFF, 16'hFF81, EE ? 1 : 4, "max_m1");
        run_op(8'h00, 8'hB3, 16'h0000, 4, "zero_m77");

        // Early-exit vectors (counts are N/2 when the option is off)
        run_op(8'hFB, 8'h01, 16'hFFFB, EE ? 1 : 4, "m5_b1");
        run_op(8'h06, 8'hFF, 16'hFFFA, EE ? 1 : 4, "a6_m1");
        run_op(8'h03, 8'h40, 16'h00C0, 4, "a3_b40");

        // Start held high with new operands every cycle; only IDLE-cycle operands count.
        acc_n = 0;
        done_n = 0;
        last_done = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("stream_excl", bus.done & bus.ready, 1'b0);
            if (bus.done) begin
                done_n++;
                if (eq.size() > 0) begin
                    c_pop = ecq.pop_front();
                    chk("stream_prod", bus.product, eq.pop_front());
                    chk("stream_cnt", bus.iter_cnt, c_pop);
                    if (last_done >= 0) chk("stream_gap", c - last_done, c_pop + 2);
                end
                last_done = c;
            end
            if (c < 24) begin
                sa = 8'(c * 37 - 100);
                sb = 8'(91 - c * 23);
                bus.start = 1'b1;
                bus.a = sa;
                bus.b = sb;
                if (bus.ready) begin
                    acc_n++;
                    pe = sa * sb;
                    eq.push_back(pe);
                    ecq.push_back(exp_cnt(sb));
                end
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("stream_done_vs_accept", done_n, acc_n);
        chk("stream_left", eq.size(), 0);

        // Reset pulse in the middle of 7*9
        wait_ready("rst_mid");
        bus.start = 1'b1;
        bus.a = 8'd7;
        bus.b = 8'd9;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", bus.ready, 1'b1);
        chk("rst_mid_busy", bus.busy, 1'b0);
        chk("rst_mid_done", bus.done, 1'b0);
        chk("rst_mid_product", bus.product, 16'h0000);
        chk("rst_mid_iter_cnt", bus.iter_cnt, 3'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        chk("rst_mid_no_done", seen, 1'b0);
        run_op(8'd7, 8'd9, 16'd63, EE ? 3 : 4, "a7_b9");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
